rtc_mtime_unit: RTL and testbench

//  Consumer of the synchronized RTC level from the n-stage synchronizer.
//  - Detects rising edges of the RTC and advances a 64-bit mtime on each edge.
//  - Compares mtime against one 64-bit mtimecmp per hart and raises per-hart timer IRQs.
//  - Exposes mtime/mtimecmp through a 32-bit word register port.

---
 rtl/rtc_mtime_unit.sv | 87 ++++++++
 tb/tb_rtc_mtime_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rtc_mtime_unit.sv
// rtc_mtime_unit: 64-bit mtime advanced on synchronized RTC rising edges, per-hart mtimecmp and timer IRQs.
// Word register port: 0 MTIME_LO, 1 MTIME_HI, 2+2h CMP_LO[h], 3+2h CMP_HI[h]; responses one cycle after req_i.
module rtc_mtime_unit #(
   parameter int unsigned NR_HARTS = 1,
   parameter int unsigned ADDR_W   = $clog2(2*NR_HARTS+2)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rtc_synch_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [31:0]         wdata_i,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   output logic                err_o,
   output logic [NR_HARTS-1:0] irq_o
);
   localparam int unsigned NREG   = 2*NR_HARTS+2;
   localparam int unsigned NWORDS = 1 << ADDR_W;

   logic                rtc_q, tick, valid, wr;
   logic [63:0]         mtime_q, mtime_d;
   logic [63:0]         cmp_q [NR_HARTS];
   logic [63:0]         cmp_d [NR_HARTS];
   logic [NR_HARTS-1:0] irq_q, irq_d;
   logic [31:0]         word [NWORDS];
   logic [31:0]         rdata_q, rdata_d;
   logic                rvalid_q, err_q;

   assign tick  = rtc_synch_i & ~rtc_q;
   assign valid = {1'b0, addr_i} < (ADDR_W+1)'(NREG);
   assign wr    = req_i & we_i & valid;

   // A write to MTIME_LO swallows a coincident tick; MTIME_HI keeps it on the low half only.
   always_comb begin
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr && addr_i == ADDR_W'(0)) mtime_d = {mtime_q[63:32], wdata_i};
      if (wr && addr_i == ADDR_W'(1)) mtime_d = {wdata_i, tick ? mtime_q[31:0] + 32'd1 : mtime_q[31:0]};
   end

   always_comb begin
      for (int h = 0; h < NR_HARTS; h++) begin
         cmp_d[h] = cmp_q[h];
         if (wr && addr_i == ADDR_W'(2+2*h)) cmp_d[h][31:0]  = wdata_i;
         if (wr && addr_i == ADDR_W'(3+2*h)) cmp_d[h][63:32] = wdata_i;
         irq_d[h] = mtime_d >= cmp_d[h];
      end
   end

   // Unmapped words read as zero, so error responses carry rdata 0 without extra gating.
   always_comb begin
      for (int i = 0; i < NWORDS; i++) word[i] = 32'd0;
      word[0] = mtime_q[31:0];
      word[1] = mtime_q[63:32];
      for (int h = 0; h < NR_HARTS; h++) begin
         word[2+2*h] = cmp_q[h][31:0];
         word[3+2*h] = cmp_q[h][63:32];
      end
      rdata_d = (req_i && !we_i) ? word[addr_i] : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rtc_q    <= 1'b0;
         mtime_q  <= 64'd0;
         for (int h = 0; h < NR_HARTS; h++) cmp_q[h] <= '1;
         irq_q    <= '0;
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rtc_q    <= rtc_synch_i;
         mtime_q  <= mtime_d;
         for (int h = 0; h < NR_HARTS; h++) cmp_q[h] <= cmp_d[h];
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         rvalid_q <= req_i;
         err_q    <= req_i & ~valid;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign irq_o    = irq_q;
endmodule

// File: tb/tb_rtc_mtime_unit.sv
// tb_rtc_mtime_unit: directed checks of rtc_mtime_unit with two harts.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_rtc_mtime_unit;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        rtc_synch_i = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [2:0]  addr_i = 3'd0;
   logic [31:0] wdata_i = 32'd0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [1:0]  irq_o;
   int          errors = 0;
   int          checks = 0;

   rtc_mtime_unit #(.NR_HARTS(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .rtc_synch_i(rtc_synch_i),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      rtc_synch_i = 1'b1;
      @(negedge clk_i);
      rtc_synch_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic exp_err, input string tag);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      @(negedge clk_i);
      req_i = 1'b0;
      chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd1);
      chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
      chk(tag, 64'(rdata_o), 64'(exp));
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic exp_err, input string tag);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0;
      chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd1);
      chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
      chk({tag, "_rdata"}, 64'(rdata_o), 64'd0);
   endtask

   initial begin
      // 1: reset values, five ticks, single-cycle response
      repeat (2) @(negedge clk_i);
      chk("rst_irq", 64'(irq_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_rdata", 64'(rdata_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      repeat (5) tick();
      rd(3'd0, 32'd5, 1'b0, "t1_lo");
      @(negedge clk_i);
      chk("t1_rvalid_drop", 64'(rvalid_o), 64'd0);
      rd(3'd1, 32'd0, 1'b0, "t1_hi");
      rd(3'd2, 32'hFFFF_FFFF, 1'b0, "t1_cmp0lo");
      rd(3'd5, 32'hFFFF_FFFF, 1'b0, "t1_cmp1hi");

      // 2: carry from lo into hi, then full 64-bit wrap
      wr(3'd0, 32'hFFFF_FFFF, 1'b0, "t2_wlo");
      wr(3'd1, 32'd0, 1'b0, "t2_whi");
      tick();
      rd(3'd1, 32'd1, 1'b0, "t2_carry_hi");
      rd(3'd0, 32'd0, 1'b0, "t2_carry_lo");
      wr(3'd0, 32'hFFFF_FFFF, 1'b0, "t2_wlo2");
      wr(3'd1, 32'hFFFF_FFFF, 1'b0, "t2_whi2");
      chk("t2_irq_allones", 64'(irq_o), 64'd3);
      tick();
      chk("t2_irq_wrap", 64'(irq_o), 64'd0);
      rd(3'd0, 32'd0, 1'b0, "t2_wrap_lo");
      rd(3'd1, 32'd0, 1'b0, "t2_wrap_hi");

      // 3: CMP[1]=10, irq on the 10th tick, cleared by raising CMP_LO[1]
      wr(3'd5, 32'd0, 1'b0, "t3_cmp1hi");
      wr(3'd4, 32'd10, 1'b0, "t3_cmp1lo");
      chk("t3_irq_pre", 64'(irq_o), 64'd0);
      repeat (9) tick();
      chk("t3_irq_9", 64'(irq_o), 64'd0);
      rtc_synch_i = 1'b1;
      @(negedge clk_i);
      chk("t3_irq_10", 64'(irq_o), 64'd2);
      rtc_synch_i = 1'b0;
      @(negedge clk_i);
      wr(3'd4, 32'd20, 1'b0, "t3_cmp1lo_20");
      chk("t3_irq_clr", 64'(irq_o), 64'd0);
      rd(3'd0, 32'd10, 1'b0, "t3_lo");

      // 4: writes colliding with ticks
      rtc_synch_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 3'd0; wdata_i = 32'd7;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; rtc_synch_i = 1'b0;
      chk("t4_wlo_rvalid", 64'(rvalid_o), 64'd1);
      @(negedge clk_i);
      rd(3'd0, 32'd7, 1'b0, "t4_lo7");
      wr(3'd0, 32'd4, 1'b0, "t4_wlo4");
      rtc_synch_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 3'd1; wdata_i = 32'd3;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; rtc_synch_i = 1'b0;
      @(negedge clk_i);
      rd(3'd1, 32'd3, 1'b0, "t4_hi3");
      rd(3'd0, 32'd5, 1'b0, "t4_lo5");
      chk("t4_irq", 64'(irq_o), 64'd2);

      // 5: invalid addresses, then a read racing a tick
      rd(3'd6, 32'd0, 1'b1, "t5_rd6");
      rd(3'd7, 32'd0, 1'b1, "t5_rd7");
      wr(3'd6, 32'd0, 1'b1, "t5_wr6");
      rd(3'd0, 32'd5, 1'b0, "t5_lo_keep");
      rd(3'd1, 32'd3, 1'b0, "t5_hi_keep");
      rd(3'd4, 32'd20, 1'b0, "t5_cmp1lo_keep");
      rtc_synch_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 3'd0;
      @(negedge clk_i);
      req_i = 1'b0; rtc_synch_i = 1'b0;
      chk("t5_race_old", 64'(rdata_o), 64'd5);
      @(negedge clk_i);
      rd(3'd0, 32'd6, 1'b0, "t5_race_new");

      // 6: asynchronous reset with irq high and a response in flight
      chk("t6_irq_pre", 64'(irq_o), 64'd2);
      req_i = 1'b1; we_i = 1'b0; addr_i = 3'd0;
      @(posedge clk_i);
      #2;
      req_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("t6_irq_async", 64'(irq_o), 64'd0);
      chk("t6_rvalid_async", 64'(rvalid_o), 64'd0);
      chk("t6_rdata_async", 64'(rdata_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      rd(3'd0, 32'd0, 1'b0, "t6_lo");
      rd(3'd1, 32'd0, 1'b0, "t6_hi");
      rd(3'd2, 32'hFFFF_FFFF, 1'b0, "t6_cmp0lo");
      rd(3'd3, 32'hFFFF_FFFF, 1'b0, "t6_cmp0hi");
      rd(3'd4, 32'hFFFF_FFFF, 1'b0, "t6_cmp1lo");
      rd(3'd5, 32'hFFFF_FFFF, 1'b0, "t6_cmp1hi");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
